// File: rtl/if_id_stage_pkg.sv
// rtl/if_id_stage_pkg.sv - shared CPU constants, PCSrc encodings and fetch-stage helpers
package if_id_stage_pkg;

  localparam logic [31:0] RESET_VECTOR = 32'h8000_0000;
  localparam logic [31:0] ILLOP_VECTOR = 32'h8000_0004;
  localparam logic [31:0] XADR_VECTOR  = 32'h8000_0008;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;

  localparam logic [2:0] PCSRC_PLUS4 = 3'b000;
  localparam logic [2:0] PCSRC_JR    = 3'b010;
  localparam logic [2:0] PCSRC_JUMP  = 3'b011;
  localparam logic [2:0] PCSRC_ILLOP = 3'b100;
  localparam logic [2:0] PCSRC_XADR  = 3'b101;

  typedef enum logic [1:0] {
    ACT_FETCH = 2'd0,
    ACT_FLUSH = 2'd1,
    ACT_HOLD  = 2'd2
  } if_act_e;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] cnt);
    return (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
  endfunction

endpackage

// File: rtl/if_id_stage_pc_next_sel.sv
// rtl/if_id_stage_pc_next_sel.sv - first-match next-PC and IF/ID action select
module pc_next_sel
  import if_id_stage_pkg::*;
(
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  input  logic [2:0]  pcsrc_i,
  input  logic        stall_i,
  input  logic [31:0] jr_target_i,
  input  logic [31:0] jump_target_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] pc_plus4_i,
  output logic [31:0] next_pc_o,
  output if_act_e     act_o
);

  logic [31:0] raw_pc;

  // EX redirect and traps beat the load-use stall; ID jumps yield to it.
  always_comb begin
    raw_pc = pc_plus4_i;
    act_o  = ACT_FETCH;
    if (branch_taken_i) begin
      raw_pc = branch_target_i;
      act_o  = ACT_FLUSH;
    end else if (pcsrc_i == PCSRC_ILLOP) begin
      raw_pc = ILLOP_VECTOR;
      act_o  = ACT_FLUSH;
    end else if (pcsrc_i == PCSRC_XADR) begin
      raw_pc = XADR_VECTOR;
      act_o  = ACT_FLUSH;
    end else if (stall_i) begin
      raw_pc = pc_i;
      act_o  = ACT_HOLD;
    end else if (pcsrc_i == PCSRC_JR) begin
      raw_pc = jr_target_i;
      act_o  = ACT_FLUSH;
    end else if (pcsrc_i == PCSRC_JUMP) begin
      raw_pc = jump_target_i;
      act_o  = ACT_FLUSH;
    end
  end

  assign next_pc_o = word_align(raw_pc);

endmodule

// File: rtl/if_id_stage.sv
// rtl/if_id_stage.sv - PC register, IF/ID pipeline register and stall/flush counters
module if_id_stage
  import if_id_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        Stall,
  input  logic [2:0]  PCSrc,
  input  logic [31:0] ID_JrTarget,
  input  logic [31:0] ID_JumpTarget,
  input  logic        EX_BranchTaken,
  input  logic [31:0] EX_BranchTarget,
  input  logic [31:0] Instruction_in,
  output logic [31:0] PC,
  output logic [31:0] IF_ID_Instruction,
  output logic [31:0] IF_ID_PC_plus4,
  output logic        IF_ID_Valid,
  output logic [15:0] StallCycles,
  output logic [15:0] FlushCount
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;
  logic [31:0] pc_plus4;
  logic [31:0] next_pc;
  if_act_e     act;

  // Bit 31 is the supervisor flag; only the low 31 bits advance.
  assign pc_plus4 = {pc_q[31], pc_q[30:0] + 31'd4};

  pc_next_sel u_pc_next_sel (
    .branch_taken_i  (EX_BranchTaken),
    .branch_target_i (EX_BranchTarget),
    .pcsrc_i         (PCSrc),
    .stall_i         (Stall),
    .jr_target_i     (ID_JrTarget),
    .jump_target_i   (ID_JumpTarget),
    .pc_i            (pc_q),
    .pc_plus4_i      (pc_plus4),
    .next_pc_o       (next_pc),
    .act_o           (act)
  );

  always_comb begin
    pc_d        = next_pc;
    instr_d     = instr_q;
    pc4_d       = pc4_q;
    valid_d     = valid_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    case (act)
      ACT_FLUSH: begin
        instr_d     = NOP_INSTR;
        pc4_d       = 32'h0000_0000;
        valid_d     = 1'b0;
        flush_cnt_d = sat_inc(flush_cnt_q);
      end
      ACT_HOLD: begin
        stall_cnt_d = sat_inc(stall_cnt_q);
      end
      default: begin
        instr_d = Instruction_in;
        pc4_d   = pc_plus4;
        valid_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q        <= RESET_VECTOR;
      instr_q     <= NOP_INSTR;
      pc4_q       <= 32'h0000_0000;
      valid_q     <= 1'b0;
      stall_cnt_q <= 16'h0000;
      flush_cnt_q <= 16'h0000;
    end else begin
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      pc4_q       <= pc4_d;
      valid_q     <= valid_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign PC                = pc_q;
  assign IF_ID_Instruction = instr_q;
  assign IF_ID_PC_plus4    = pc4_q;
  assign IF_ID_Valid       = valid_q;
  assign StallCycles       = stall_cnt_q;
  assign FlushCount        = flush_cnt_q;

endmodule

// File: doc/if_id_stage.md
IF_ID_STAGE -- requirements
Module: if_id_stage

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1; synchronous, active-high.
REQ-003 SHALL have port Stall, input, 1; load-use stall from hazard unit; hold PC and IF/ID.
REQ-004 SHALL have port PCSrc, input, 3; ID-stage PC select: 000 PC+4, 010 jr, 011 j/jal, 100 ILLOP, 101 XADR; 001/110/111 treated as 000.
REQ-005 SHALL have ports ID_JrTarget and ID_JumpTarget, input, 32 each; redirect targets from ID.
REQ-006 SHALL have ports EX_BranchTaken (input, 1) and EX_BranchTarget (input, 32); resolved branch from EX.
REQ-007 SHALL have port Instruction_in, input, 32; combinational instruction-memory read data at PC.
REQ-008 SHALL have port PC, output, 32; current fetch address.
REQ-009 SHALL have ports IF_ID_Instruction (output, 32), IF_ID_PC_plus4 (output, 32) and IF_ID_Valid (output, 1).
REQ-010 SHALL have ports StallCycles and FlushCount, output, 16 each; saturating event counters.

Function
REQ-011 PC_plus4 SHALL equal {PC[31], PC[30:0]+4}; low 31 bits wrap modulo 2^31; bit 31 (supervisor) preserved.
REQ-012 Each cycle, next state SHALL be selected by first-match priority: reset, EX_BranchTaken, PCSrc 100/101, Stall, PCSrc 010/011, default.
REQ-013 EX_BranchTaken=1: PC <= EX_BranchTarget; IF/ID <= bubble; FlushCount increments; Stall ignored.
REQ-014 PCSrc=100: PC <= 0x80000004; PCSrc=101: PC <= 0x80000008; both load a bubble into IF/ID and increment FlushCount, regardless of Stall.
REQ-015 Stall=1 (no higher-priority event): PC, IF_ID_Instruction, IF_ID_PC_plus4 and IF_ID_Valid hold; StallCycles increments.
REQ-016 PCSrc=010: PC <= ID_JrTarget; PCSrc=011: PC <= ID_JumpTarget; both load a bubble into IF/ID (no delay slot) and increment FlushCount.
REQ-017 Default: PC <= PC_plus4; IF_ID_Instruction <= Instruction_in; IF_ID_PC_plus4 <= PC_plus4; IF_ID_Valid <= 1.
REQ-018 Every value loaded into PC SHALL have bits [1:0] forced to 00.
REQ-019 Bubble SHALL be IF_ID_Instruction=0x00000000, IF_ID_PC_plus4=0x00000000, IF_ID_Valid=0.
REQ-020 Counters SHALL saturate at 0xFFFF and never wrap; at most one counter increments per cycle.
REQ-021 Latency: a redirect presented in cycle N SHALL appear on PC in cycle N+1; the first target instruction SHALL reach IF/ID in cycle N+2.
REQ-022 Consecutive stall cycles SHALL be unbounded; the held instruction SHALL be released in the first cycle with Stall=0.

Reset
REQ-023 On reset=1 at a rising edge: PC=0x80000000, IF/ID=bubble, StallCycles=0, FlushCount=0, all other inputs ignored.
REQ-024 Reset asserted mid-stall or mid-redirect SHALL take effect in that cycle and discard the pending event.

Structure
REQ-025 Constants RESET_VECTOR 0x80000000, ILLOP_VECTOR 0x80000004, XADR_VECTOR 0x80000008, NOP_INSTR 0x00000000 and the PCSrc encodings SHALL reside in the shared CPU package.
REQ-026 The next-PC priority selection SHALL be one combinational sub-module, pc_next_sel; PC, IF/ID and counter registers SHALL stay in if_id_stage.

Verification
REQ-027 Reset then 3 cycles default, Instruction_in=0x20080001 -> PC 0x80000000, 0x80000004, 0x80000008, 0x8000000C; IF_ID_PC_plus4=0x8000000C, Valid=1.
REQ-028 Stall=1 for 2 cycles at PC=0x00000010 -> PC and IF/ID hold 2 cycles; StallCycles=2; PC=0x00000014 on the cycle after release.
REQ-029 Stall=1, EX_BranchTaken=1, target 0x00000040, same cycle -> PC=0x00000040, IF_ID_Valid=0, FlushCount=1, StallCycles unchanged.
REQ-030 PCSrc=010, ID_JrTarget=0x00000103 -> PC=0x00000100, IF/ID bubble; PCSrc=101 with Stall=1 -> PC=0x80000008.
REQ-031 PC=0x7FFFFFFC default -> PC=0x00000000; PC=0xFFFFFFFC -> PC=0x80000000; StallCycles preset to 0xFFFF by 65535 stall cycles, one more -> stays 0xFFFF.
REQ-032 reset=1 during Stall=1 with FlushCount=5 -> PC=0x80000000, counters 0, IF_ID_Valid=0 next cycle.
